inst_decode_stage: RTL

INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

---
 rtl/inst_decode_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/inst_decode_stage.sv
// Single-entry decode stage: splits an instruction word into register specifiers and an
// extended immediate, with a valid/ready handshake and a saturating illegal-instruction counter.
module inst_decode_stage #(
    parameter int INST_W   = 32,
    parameter int REG_AW   = 5,
    parameter int IMM_W    = 16,
    parameter int XLEN     = 32,
    parameter int SIGN_EXT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_type,
    output logic [3:0]        out_opcode,
    output logic [REG_AW-1:0] out_src1,
    output logic [REG_AW-1:0] out_src2,
    output logic [REG_AW-1:0] out_dest,
    output logic [REG_AW-1:0] out_cond,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam int F0_LSB = 6;
    localparam int F1_LSB = 6 + REG_AW;
    localparam int F2_LSB = 6 + 2 * REG_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] TYPE_ILL = 2'b00;
    localparam logic [1:0] TYPE_S   = 2'b01;
    localparam logic [1:0] TYPE_I   = 2'b10;
    localparam logic [1:0] TYPE_B   = 2'b11;

    generate
        if (INST_W < 6 + 3 * REG_AW) begin : g_bad_reg_fields
            $error("inst_decode_stage: INST_W too small for three register fields");
        end
        if (INST_W < 6 + 2 * REG_AW + IMM_W) begin : g_bad_imm_field
            $error("inst_decode_stage: INST_W too small for two register fields plus immediate");
        end
        if (XLEN < IMM_W) begin : g_bad_xlen
            $error("inst_decode_stage: XLEN must be at least IMM_W");
        end
    endgenerate

    // Raw fields of the incoming word
    logic [1:0]        inst_type;
    logic [3:0]        inst_opcode;
    logic [REG_AW-1:0] f0;
    logic [REG_AW-1:0] f1;
    logic [REG_AW-1:0] f2;
    logic [IMM_W-1:0]  imm_field;
    logic [XLEN-1:0]   imm_ext;

    assign inst_type   = in_inst[1:0];
    assign inst_opcode = in_inst[5:2];
    assign f0          = in_inst[F0_LSB +: REG_AW];
    assign f1          = in_inst[F1_LSB +: REG_AW];
    assign f2          = in_inst[F2_LSB +: REG_AW];
    assign imm_field   = in_inst[INST_W-1 -: IMM_W];

    assign imm_ext[IMM_W-1:0] = imm_field;
    generate
        for (genvar gi = IMM_W; gi < XLEN; gi++) begin : g_imm_ext
            assign imm_ext[gi] = (SIGN_EXT != 0) ? imm_field[IMM_W-1] : 1'b0;
        end
    endgenerate

    // Decoded bundle for the word currently on in_inst
    logic [REG_AW-1:0] src1_next;
    logic [REG_AW-1:0] src2_next;
    logic [REG_AW-1:0] dest_next;
    logic [REG_AW-1:0] cond_next;
    logic [XLEN-1:0]   imm_next;
    logic              illegal_next;

    always_comb begin
        src1_next    = '0;
        src2_next    = '0;
        dest_next    = '0;
        cond_next    = '0;
        imm_next     = '0;
        illegal_next = 1'b0;
        case (inst_type)
            TYPE_S: begin
                src1_next = f0;
                src2_next = f1;
                dest_next = f2;
            end
            TYPE_I: begin
                src1_next = f0;
                dest_next = f1;
                imm_next  = imm_ext;
            end
            TYPE_B: begin
                src2_next = f0;
                dest_next = f0;
                cond_next = f1;
                imm_next  = imm_ext;
            end
            default: begin
                illegal_next = 1'b1;
            end
        endcase
    end

    // Bundle registers
    logic              valid_reg;
    logic [1:0]        type_reg;
    logic [3:0]        opcode_reg;
    logic [REG_AW-1:0] src1_reg;
    logic [REG_AW-1:0] src2_reg;
    logic [REG_AW-1:0] dest_reg;
    logic [REG_AW-1:0] cond_reg;
    logic [XLEN-1:0]   imm_reg;
    logic              illegal_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic accept;
    logic cnt_bump;

    // The stage can take a new word when empty or when the current bundle leaves this cycle
    assign in_ready = !flush && (!valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign cnt_bump = accept && (inst_type == TYPE_ILL) && (cnt_reg != CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            type_reg    <= '0;
            opcode_reg  <= '0;
            src1_reg    <= '0;
            src2_reg    <= '0;
            dest_reg    <= '0;
            cond_reg    <= '0;
            imm_reg     <= '0;
            illegal_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg   <= 1'b1;
            type_reg    <= inst_type;
            opcode_reg  <= inst_opcode;
            src1_reg    <= src1_next;
            src2_reg    <= src2_next;
            dest_reg    <= dest_next;
            cond_reg    <= cond_next;
            imm_reg     <= imm_next;
            illegal_reg <= illegal_next;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // Counter ignores flush: accept is already masked by it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (cnt_bump) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign out_valid   = valid_reg;
    assign out_type    = type_reg;
    assign out_opcode  = opcode_reg;
    assign out_src1    = src1_reg;
    assign out_src2    = src2_reg;
    assign out_dest    = dest_reg;
    assign out_cond    = cond_reg;
    assign out_imm     = imm_reg;
    assign out_illegal = illegal_reg;
    assign illegal_cnt = cnt_reg;

endmodule
